// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: word-access SRAM slave behind the cpu mem arbiter.
// Fixed-latency SRAM reads, in-order responses, fault on bad address.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_*_i/_o      request channel (valid/ready), byte address, write
//                   flag, byte enables, write data
//   resp_*_o/_i     response channel (valid/ready), read data, fault flag
//   sram_*_o        single-port synchronous SRAM strobe, byte write
//                   enables, word index and write data
//   sram_rdata_i    SRAM read data, READ_LAT cycles after the strobe
module mem_sram_ctrl #(
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 16384,
    parameter int          READ_LAT    = 1,
    parameter int          RESP_DEPTH  = 2,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [31:0]   req_addr_i,
    input  logic          req_we_i,
    input  logic [3:0]    req_be_i,
    input  logic [31:0]   req_wdata_i,
    output logic          resp_valid_o,
    input  logic          resp_ready_i,
    output logic [31:0]   resp_rdata_o,
    output logic          resp_err_o,
    output logic          sram_en_o,
    output logic [3:0]    sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i
);

    localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW  = $clog2(RESP_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int H   = READ_LAT - 1;

    // Range limits in 33 bits so the top of the address space cannot wrap.
    localparam logic [32:0] LO  = {1'b0, BASE};
    localparam logic [32:0] HI  = LO + 33'(4 * DEPTH_WORDS);
    localparam logic [CW:0] CAP = CW1'(RESP_DEPTH);

    // ------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------
    logic [32:0] addr_x;
    logic [31:0] off;
    logic        ok;
    logic        accept;

    assign addr_x = {1'b0, req_addr_i};
    assign off    = req_addr_i - BASE;
    assign ok     = (req_addr_i[1:0] == 2'b00)
                 && (addr_x >= LO)
                 && (addr_x < HI);
    assign accept = req_valid_i && req_ready_o;

    // Faulting requests never strobe the SRAM.
    assign sram_en_o    = accept && ok;
    assign sram_we_o    = (accept && ok && req_we_i) ? req_be_i : 4'b0000;
    assign sram_addr_o  = AW'(off >> 2);
    assign sram_wdata_o = req_wdata_i;

    // ------------------------------------------------------------
    // Delay pipe: one stage per SRAM latency cycle. Writes and faults
    // ride the same pipe so every response comes out in order.
    // ------------------------------------------------------------
    logic [READ_LAT-1:0] pv_q;
    logic [READ_LAT-1:0] prd_q;
    logic [READ_LAT-1:0] perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q   <= '0;
            prd_q  <= '0;
            perr_q <= '0;
        end else begin
            pv_q[0]   <= accept;
            prd_q[0]  <= accept && !req_we_i;
            perr_q[0] <= accept && !ok;
            for (int i = 1; i < READ_LAT; i++) begin
                pv_q[i]   <= pv_q[i-1];
                prd_q[i]  <= prd_q[i-1];
                perr_q[i] <= perr_q[i-1];
            end
        end
    end

    logic        head_v;
    logic        head_err;
    logic [31:0] head_rdata;

    assign head_v     = pv_q[H];
    assign head_err   = perr_q[H];
    assign head_rdata = (prd_q[H] && !perr_q[H]) ? sram_rdata_i : 32'h0;

    // ------------------------------------------------------------
    // Response buffer (circular FIFO of {err, rdata})
    // ------------------------------------------------------------
    logic [32:0]   buf_q [RESP_DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] infl_q, infl_d;
    logic          buf_empty;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign buf_empty = (cnt_q == '0);

    // Buffer head is always presented first; the pipe head only
    // bypasses when the buffer is empty, and skips storage if taken.
    assign pop  = !buf_empty && resp_ready_i;
    assign push = head_v && !(buf_empty && resp_ready_i);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) begin
            wr_d = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Entries in the delay pipe that still hold a response credit.
    always_comb begin
        infl_d = infl_q;
        unique case ({accept, head_v})
            2'b10:   infl_d = infl_q + 1'b1;
            2'b01:   infl_d = infl_q - 1'b1;
            default: infl_d = infl_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            infl_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
        end
    end

    // Storage needs no reset; cnt_q decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_q] <= {head_err, head_rdata};
        end
    end

    // ------------------------------------------------------------
    // Credit and response outputs
    // ------------------------------------------------------------
    // Reserving a slot per accepted request keeps the buffer from
    // ever overflowing, whatever resp_ready does.
    assign req_ready_o = !rst
                      && (({1'b0, infl_q} + {1'b0, cnt_q}) < CAP);

    always_comb begin
        resp_valid_o = 1'b0;
        resp_rdata_o = 32'h0;
        resp_err_o   = 1'b0;
        if (!buf_empty) begin
            resp_valid_o = 1'b1;
            {resp_err_o, resp_rdata_o} = buf_q[rd_q];
        end else if (head_v) begin
            resp_valid_o = 1'b1;
            resp_rdata_o = head_rdata;
            resp_err_o   = head_err;
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: bench for mem_sram_ctrl.
// Two instances: READ_LAT=1/RESP_DEPTH=2 and READ_LAT=2/RESP_DEPTH=3.
module tb_mem_sram_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rv   [2];
    logic        rr   [2];
    logic [31:0] ra   [2];
    logic        rwe  [2];
    logic [3:0]  rbe  [2];
    logic [31:0] rwd  [2];
    logic        pv   [2];
    logic        pr   [2];
    logic        rdy  [2];
    logic [31:0] prd  [2];
    logic        pe   [2];
    logic        sen  [2];
    logic [3:0]  swe  [2];
    logic [13:0] sad  [2];
    logic [31:0] swd  [2];
    logic [31:0] srd  [2];

    logic        rbp;
    logic        bp_rnd;

    assign rdy[0] = pr[0];
    assign rdy[1] = pr[1] & ~(rbp & bp_rnd);

    mem_sram_ctrl #(
        .BASE(BASE), .DEPTH_WORDS(16384), .READ_LAT(1), .RESP_DEPTH(2)
    ) u_a (
        .clk(clk), .rst(rst),
        .req_valid_i(rv[0]), .req_ready_o(rr[0]), .req_addr_i(ra[0]),
        .req_we_i(rwe[0]), .req_be_i(rbe[0]), .req_wdata_i(rwd[0]),
        .resp_valid_o(pv[0]), .resp_ready_i(rdy[0]),
        .resp_rdata_o(prd[0]), .resp_err_o(pe[0]),
        .sram_en_o(sen[0]), .sram_we_o(swe[0]), .sram_addr_o(sad[0]),
        .sram_wdata_o(swd[0]), .sram_rdata_i(srd[0])
    );

    mem_sram_ctrl #(
        .BASE(BASE), .DEPTH_WORDS(16384), .READ_LAT(2), .RESP_DEPTH(3)
    ) u_b (
        .clk(clk), .rst(rst),
        .req_valid_i(rv[1]), .req_ready_o(rr[1]), .req_addr_i(ra[1]),
        .req_we_i(rwe[1]), .req_be_i(rbe[1]), .req_wdata_i(rwd[1]),
        .resp_valid_o(pv[1]), .resp_ready_i(rdy[1]),
        .resp_rdata_o(prd[1]), .resp_err_o(pe[1]),
        .sram_en_o(sen[1]), .sram_we_o(swe[1]), .sram_addr_o(sad[1]),
        .sram_wdata_o(swd[1]), .sram_rdata_i(srd[1])
    );

    // SRAM models with a preload port.
    logic [31:0] mem [2][16384];
    logic [31:0] sq  [2][2];
    logic        pl_en  [2];
    logic [13:0] pl_idx [2];
    logic [31:0] pl_d   [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pl_en[k]) mem[k][pl_idx[k]] <= pl_d[k];
            if (sen[k]) begin
                for (int b = 0; b < 4; b++)
                    if (swe[k][b])
                        mem[k][sad[k]][8*b +: 8] <= swd[k][8*b +: 8];
                sq[k][0] <= mem[k][sad[k]];
            end
            sq[k][1] <= sq[k][0];
        end
    end

    assign srd[0] = sq[0][0];
    assign srd[1] = sq[1][1];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;
    int   lat [2];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            bp_rnd = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Response monitor: scoreboard pop, latency and stall stability.
    logic        held [2];
    logic [32:0] hval [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                held[k] = 1'b0;
            end else begin
                if (held[k]) begin
                    chk("stall_valid", 32'(pv[k]), 32'd1);
                    chk("stall_data", prd[k], hval[k][31:0]);
                    chk("stall_err", 32'(pe[k]), 32'(hval[k][32]));
                end
                if (pv[k] && rdy[k]) begin
                    if (qsize(k) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp%0d: got %h want none",
                                 k, prd[k]);
                    end else begin
                        if (k == 0) mon_e = q0.pop_front();
                        else mon_e = q1.pop_front();
                        chk("resp_rdata", prd[k], mon_e.rdata);
                        chk("resp_err", 32'(pe[k]), 32'(mon_e.err));
                        if (mon_e.chk)
                            chk("latency", 32'(cyc - mon_e.t), 32'(lat[k]));
                    end
                end
                held[k] = pv[k] && !rdy[k];
                hval[k] = {pe[k], prd[k]};
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the request still
    // driven so back-to-back calls keep req_valid high.
    task automatic send(input int k, input vec_t v,
                        input logic chk_lat, input logic chk_rdy);
        int w;
        w = 0;
        rv[k]  = 1'b1;
        rwe[k] = v.we;
        ra[k]  = v.addr;
        rbe[k] = v.be;
        rwd[k] = v.wdata;
        @(negedge clk);
        while (!rr[k] && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!rr[k]) begin
            total++;
            bad++;
            $display("FAIL req_timeout%0d: got ready 0 want 1", k);
            rv[k] = 1'b0;
        end else begin
            push(k, '{v.rdata, v.err, chk_lat, cyc});
            chk("sram_en", 32'(sen[k]), 32'(!v.err));
            chk("sram_we", 32'(swe[k]),
                32'((!v.err && v.we) ? v.be : 4'h0));
            if (!v.err) begin
                chk("sram_addr", 32'(sad[k]), 32'(v.addr[15:2]));
                chk("sram_wdata", swd[k], v.wdata);
            end
            if (chk_rdy) chk("ready_first", 32'(w), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        rv[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int w;
        w = 0;
        while (qsize(k) != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (qsize(k) != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout%0d: got %0d pending want 0",
                     k, qsize(k));
            if (k == 0) q0.delete();
            else q1.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int k, input int idx,
                           input logic [31:0] d);
        pl_en[k]  = 1'b1;
        pl_idx[k] = 14'(idx);
        pl_d[k]   = d;
        @(posedge clk);
        #1;
        pl_en[k] = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h111;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    vec_t        tbl [14];
    logic [31:0] ref1 [8];

    initial begin
        vec_t        v;
        int          wi;
        logic [31:0] m;

        tbl[0]  = '{1'b0, 32'h8000_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[1]  = '{1'b1, 32'h8000_0004, 4'h2, 32'h0000_AB00, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h8000_0004, 4'hF, 32'h0, 32'h1122_AB44, 1'b0};
        tbl[3]  = '{1'b0, 32'h7FFF_FFFC, 4'hF, 32'h0, 32'h0, 1'b1};
        tbl[4]  = '{1'b0, 32'h8001_0000, 4'hF, 32'h0, 32'h0, 1'b1};
        tbl[5]  = '{1'b0, 32'h8000_0002, 4'hF, 32'h0, 32'h0, 1'b1};
        tbl[6]  = '{1'b1, 32'h8000_FFFC, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 32'h8000_FFFC, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0};
        tbl[8]  = '{1'b1, 32'hFFFF_FFFC, 4'hF, 32'h1234_5678, 32'h0, 1'b1};
        tbl[9]  = '{1'b0, 32'h8000_FFFC, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0};
        tbl[10] = '{1'b1, 32'h8000_0001, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b1};
        tbl[11] = '{1'b0, 32'h8000_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[12] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, 32'h0, 1'b1};
        tbl[13] = '{1'b0, 32'h8000_0008, 4'hF, 32'h0, 32'h55AA_55AA, 1'b0};

        lat[0] = 1;
        lat[1] = 2;
        rst = 1'b1;
        rbp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b0; ra[k] = 32'h0; rwe[k] = 1'b0;
            rbe[k] = 4'h0; rwd[k] = 32'h0; pr[k] = 1'b1;
            pl_en[k] = 1'b0; pl_idx[k] = 14'h0; pl_d[k] = 32'h0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        rv[0] = 1'b1;
        rv[1] = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", 32'(rr[k]), 32'd0);
            chk("rst_resp_valid", 32'(pv[k]), 32'd0);
            chk("rst_sram_en", 32'(sen[k]), 32'd0);
            chk("rst_sram_we", 32'(swe[k]), 32'd0);
            chk("rst_rdata", prd[k], 32'h0);
            chk("rst_err", 32'(pe[k]), 32'd0);
        end
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        preload(0, 0, 32'hDEAD_BEEF);
        preload(0, 1, 32'h1122_3344);
        preload(0, 2, 32'h55AA_55AA);
        for (int i = 0; i < 8; i++) preload(1, i, pat(i));

        // Decode, byte enables, faults, full-rate latency on instance A
        for (int i = 0; i < 14; i++) send(0, tbl[i], 1'b1, 1'b1);
        idle(0);
        drain(0);

        // Backpressure: credit limit of two, then in-order drain
        pr[0] = 1'b0;
        send(0, tbl[0], 1'b0, 1'b1);
        send(0, tbl[2], 1'b0, 1'b1);
        rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = 32'h8000_0008;
        repeat (3) begin
            @(negedge clk);
            chk("credit_ready", 32'(rr[0]), 32'd0);
            chk("credit_head", prd[0], 32'hDEAD_BEEF);
        end
        @(posedge clk);
        #1;
        pr[0] = 1'b1;
        send(0, tbl[13], 1'b0, 1'b0);
        idle(0);
        drain(0);

        // 8 back-to-back reads, READ_LAT=2, RESP_DEPTH=3
        for (int i = 0; i < 8; i++) begin
            v = '{1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, pat(i), 1'b0};
            send(1, v, 1'b1, 1'b1);
        end
        idle(1);
        drain(1);

        // Random traffic against random backpressure on instance B
        for (int i = 0; i < 8; i++) ref1[i] = pat(i);
        rbp = 1'b1;
        for (int n = 0; n < 60; n++) begin
            wi = $urandom_range(0, 7);
            v.we    = 1'($urandom_range(0, 1));
            v.be    = 4'($urandom_range(1, 15));
            v.wdata = $urandom;
            v.addr  = BASE + 32'(4 * wi);
            v.err   = 1'b0;
            v.rdata = 32'h0;
            if (n % 7 == 3) begin
                v.addr = v.addr + 32'h0001_0000;
                v.err  = 1'b1;
            end else if (v.we) begin
                m = ref1[wi];
                for (int b = 0; b < 4; b++)
                    if (v.be[b]) m[8*b +: 8] = v.wdata[8*b +: 8];
                ref1[wi] = m;
            end else begin
                v.rdata = ref1[wi];
            end
            send(1, v, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
                @(posedge clk);
                #1;
            end
        end
        idle(1);
        rbp = 1'b0;
        drain(1);

        // Reset with two responses outstanding
        pr[0] = 1'b0;
        send(0, tbl[0], 1'b0, 1'b1);
        send(0, tbl[13], 1'b0, 1'b1);
        idle(0);
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", 32'(pv[0]), 32'd0);
        chk("midrst_req_ready", 32'(rr[0]), 32'd0);
        chk("midrst_rdata", prd[0], 32'h0);
        q0.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pr[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("postrst_req_ready", 32'(rr[0]), 32'd1);
        chk("postrst_resp_valid", 32'(pv[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
